// File: rtl/pc_stack_if.sv
// rtl/pc_stack_if.sv - decoder-to-program-counter bus for pc_stack
interface pc_stack_if #(
  parameter int Psize  = 5,
  parameter int Sdepth = 4,
  parameter int SPW    = $clog2(Sdepth + 1)
);
  logic             PCen;
  logic [2:0]       PCop;
  logic [Psize-1:0] Branchaddr;
  logic [Psize-1:0] Offset;
  logic             Cond;
  logic             FaultClr;
  logic [Psize-1:0] PCout;
  logic [SPW-1:0]   SPcount;
  logic             Full;
  logic             Empty;
  logic             Fault;

  // Decoder side: issues operations, observes PC and stack state
  modport master (
    output PCen, PCop, Branchaddr, Offset, Cond, FaultClr,
    input  PCout, SPcount, Full, Empty, Fault
  );

  // Program counter side
  modport slave (
    input  PCen, PCop, Branchaddr, Offset, Cond, FaultClr,
    output PCout, SPcount, Full, Empty, Fault
  );
endinterface

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - picoMIPS program counter with return-address stack
module pc_stack #(
  parameter int Psize  = 5,
  parameter int Sdepth = 4,
  parameter int SPW    = $clog2(Sdepth + 1)
) (
  input logic       clk,
  input logic       reset,
  pc_stack_if.slave bus
);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRC  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_next;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] pc_rel;
  logic [Psize-1:0] top_entry;
  logic [SPW-1:0]   sp;
  logic [Psize-1:0] stack_mem [Sdepth];
  logic             push;
  logic             pop;
  logic             fault_evt;
  logic             fault_q;
  logic             full;
  logic             empty;

  // Same-width unsigned add gives the two's-complement result modulo 2^Psize
  assign pc_inc = pc + Psize'(1);
  assign pc_rel = pc + bus.Offset;

  assign full  = (sp == SPW'(Sdepth));
  assign empty = (sp == '0);

  // Top of stack is the entry just below the occupancy count
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < Sdepth; i++) begin
      if (sp == SPW'(i + 1)) begin
        top_entry = stack_mem[i];
      end
    end
  end

  // Decode the requested operation into next PC, stack action and fault event
  always_comb begin
    pc_next   = pc;
    push      = 1'b0;
    pop       = 1'b0;
    fault_evt = 1'b0;
    if (bus.PCen) begin
      case (bus.PCop)
        OP_INC:  pc_next = pc_inc;
        OP_JMP:  pc_next = bus.Branchaddr;
        OP_BRC:  pc_next = bus.Cond ? pc_rel : pc_inc;
        OP_CALL: begin
          if (!full) begin
            push    = 1'b1;
            pc_next = bus.Branchaddr;
          end else begin
            fault_evt = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pop     = 1'b1;
            pc_next = top_entry;
          end else begin
            fault_evt = 1'b1;
          end
        end
        OP_HOLD: pc_next = pc;
        default: pc_next = pc_inc;
      endcase
    end
  end

  // PC, stack pointer and sticky fault; a new fault beats a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      sp      <= '0;
      fault_q <= 1'b0;
    end else begin
      pc <= pc_next;
      if (push) begin
        sp <= sp + SPW'(1);
      end else if (pop) begin
        sp <= sp - SPW'(1);
      end
      if (fault_evt) begin
        fault_q <= 1'b1;
      end else if (bus.FaultClr) begin
        fault_q <= 1'b0;
      end
    end
  end

  // Stack storage is never reset; entries become meaningful only once pushed
  always_ff @(posedge clk) begin
    for (int i = 0; i < Sdepth; i++) begin
      if (reset && push && (sp == SPW'(i))) begin
        stack_mem[i] <= pc_inc;
      end
    end
  end

  assign bus.PCout   = pc;
  assign bus.SPcount = sp;
  assign bus.Full    = full;
  assign bus.Empty   = empty;
  assign bus.Fault   = fault_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed self-checking bench for pc_stack
module tb_pc_stack;

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BRC  = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;
  localparam logic [2:0] HOLD = 3'b101;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_stack_if #(.Psize(5), .Sdepth(4)) bus ();

  pc_stack #(.Psize(5), .Sdepth(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic en, input logic [2:0] code, input logic [4:0] ba,
                       input logic [4:0] off, input logic c, input logic fclr);
    bus.PCen       = en;
    bus.PCop       = code;
    bus.Branchaddr = ba;
    bus.Offset     = off;
    bus.Cond       = c;
    bus.FaultClr   = fclr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [4:0] pc, input logic [2:0] sp,
                           input logic flt);
    chk({tag, "_pc"}, 32'(bus.PCout), 32'(pc));
    chk({tag, "_sp"}, 32'(bus.SPcount), 32'(sp));
    chk({tag, "_fault"}, 32'(bus.Fault), 32'(flt));
    chk({tag, "_full"}, 32'(bus.Full), 32'(sp == 3'd4));
    chk({tag, "_empty"}, 32'(bus.Empty), 32'(sp == 3'd0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.PCen = 1'b1;
    bus.PCop = INC;
    bus.Branchaddr = '0;
    bus.Offset = '0;
    bus.Cond = 1'b0;
    bus.FaultClr = 1'b0;

    // 1. asynchronous reset between edges, then INC and wrap
    #23 reset = 1'b0;
    #1;
    chk_state("reset_async", 5'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 31; i++) do_op(1'b1, INC, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("inc31", 5'd31, 3'd0, 1'b0);
    do_op(1'b1, INC, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("inc_wrap", 32'(bus.PCout), 32'd0);

    // 2. stall / JMP / BRC
    do_op(1'b1, JMP, 5'd12, 5'd0, 1'b0, 1'b0);
    chk("jmp12", 32'(bus.PCout), 32'd12);
    for (int i = 0; i < 3; i++) do_op(1'b0, JMP, 5'd3, 5'd0, 1'b0, 1'b0);
    chk("stall", 32'(bus.PCout), 32'd12);
    do_op(1'b1, BRC, 5'd0, 5'b11101, 1'b1, 1'b0);
    chk("brc_neg3", 32'(bus.PCout), 32'd9);
    do_op(1'b1, BRC, 5'd0, 5'd7, 1'b0, 1'b0);
    chk("brc_nottaken", 32'(bus.PCout), 32'd10);
    do_op(1'b1, JMP, 5'd2, 5'd0, 1'b0, 1'b0);
    do_op(1'b1, BRC, 5'd0, 5'b11100, 1'b1, 1'b0);
    chk("brc_wrap_low", 32'(bus.PCout), 32'd30);
    do_op(1'b1, 3'b110, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("rsvd110", 32'(bus.PCout), 32'd31);
    do_op(1'b1, 3'b111, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("rsvd111_wrap", 32'(bus.PCout), 32'd0);
    do_op(1'b1, HOLD, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("hold", 32'(bus.PCout), 32'd0);

    // 3. nested CALL/RET
    do_op(1'b1, JMP, 5'd3, 5'd0, 1'b0, 1'b0);
    do_op(1'b1, CALL, 5'd20, 5'd0, 1'b0, 1'b0);
    chk_state("call20", 5'd20, 3'd1, 1'b0);
    do_op(1'b1, INC, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("inc21", 32'(bus.PCout), 32'd21);
    do_op(1'b1, CALL, 5'd8, 5'd0, 1'b0, 1'b0);
    chk_state("call8", 5'd8, 3'd2, 1'b0);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret22", 5'd22, 3'd1, 1'b0);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret4", 5'd4, 3'd0, 1'b0);

    // 4. overflow: stack holds 5, 11, 12, 13
    do_op(1'b1, CALL, 5'd10, 5'd0, 1'b0, 1'b0);
    do_op(1'b1, CALL, 5'd11, 5'd0, 1'b0, 1'b0);
    do_op(1'b1, CALL, 5'd12, 5'd0, 1'b0, 1'b0);
    do_op(1'b1, CALL, 5'd31, 5'd0, 1'b0, 1'b0);
    chk_state("call_x4", 5'd31, 3'd4, 1'b0);
    do_op(1'b1, CALL, 5'd17, 5'd0, 1'b0, 1'b0);
    chk_state("call_overflow", 5'd31, 3'd4, 1'b1);
    do_op(1'b0, INC, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("fault_sticky", 32'(bus.Fault), 32'd1);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_13", 5'd13, 3'd3, 1'b1);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_12", 5'd12, 3'd2, 1'b1);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_11", 5'd11, 3'd1, 1'b1);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_5", 5'd5, 3'd0, 1'b1);

    // 5. underflow and fault clear
    do_op(1'b0, INC, 5'd0, 5'd0, 1'b0, 1'b1);
    chk_state("clr_stalled", 5'd5, 3'd0, 1'b0);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_underflow", 5'd5, 3'd0, 1'b1);
    do_op(1'b1, INC, 5'd0, 5'd0, 1'b0, 1'b1);
    chk_state("clr_inc", 5'd6, 3'd0, 1'b0);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b1);
    chk_state("set_beats_clr", 5'd6, 3'd0, 1'b1);

    // 6. reset in the middle of a call sequence
    do_op(1'b1, CALL, 5'd9, 5'd0, 1'b0, 1'b1);
    do_op(1'b1, CALL, 5'd14, 5'd0, 1'b0, 1'b0);
    chk_state("two_calls", 5'd14, 3'd2, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk_state("reset_mid", 5'd0, 3'd0, 1'b0);
    #2 reset = 1'b1;
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_after_reset", 5'd0, 3'd0, 1'b1);

    // return address wraps when calling from the top address
    do_op(1'b1, JMP, 5'd31, 5'd0, 1'b0, 1'b1);
    do_op(1'b1, CALL, 5'd7, 5'd0, 1'b0, 1'b0);
    chk_state("call_from_31", 5'd7, 3'd1, 1'b0);
    do_op(1'b1, RET, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_state("ret_wrap0", 5'd0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for picoMIPS with stall, absolute jump, conditional PC-relative branch, and subroutine call/return.
- Call/return uses an internal hardware return-address stack.
- Sits between the decoder (supplies PCop, Branchaddr, Offset, Cond) and the program ROM address port (PCout).
- Reports stack occupancy and a sticky fault flag for stack overflow/underflow.

Parameters:
- Psize, 5, PC/address width in bits (>=2).
- Sdepth, 4, return-stack depth in entries (>=1).
- SPW, $clog2(Sdepth+1), width of stack-occupancy count.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- PCen  input  1  advance enable; 0 = stall, all state held.
- PCop  input  3  operation select (encoding below).
- Branchaddr  input  Psize  absolute target for JMP/CALL.
- Offset  input  Psize  two's-complement relative displacement for BRC.
- Cond  input  1  branch condition for BRC.
- FaultClr  input  1  synchronous clear of Fault.
- PCout  output  Psize  current program counter.
- SPcount  output  SPW  number of valid return-stack entries.
- Full  output  1  SPcount == Sdepth (combinational from SPcount).
- Empty  output  1  SPcount == 0 (combinational from SPcount).
- Fault  output  1  sticky: illegal CALL on full stack or RET on empty stack.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - PCout=0, SPcount=0, Fault=0.
  - Stack contents are don't-care; they are not readable until pushed.
  - Reset asserted mid-operation aborts any pending op; the first edge after release executes normally.
- PCen=0: PCout, stack, SPcount held; Fault held unless FaultClr=1.
- PCen=1, PCop decode, all effective at the next rising edge (1-cycle latency, no bubbles):
  - 000 INC: PCout <= PCout+1.
  - 001 JMP: PCout <= Branchaddr.
  - 010 BRC:
    - Cond=1: PCout <= PCout + Offset, signed.
    - Cond=0: PCout <= PCout+1.
  - 011 CALL, not Full: push PCout+1; SPcount+1; PCout <= Branchaddr.
  - 011 CALL, Full: no push, PCout held, Fault <= 1.
  - 100 RET, not Empty: PCout <= top entry; SPcount-1.
  - 100 RET, Empty: PCout held, Fault <= 1.
  - 101 HOLD: PCout held (same as stall, but FaultClr still honoured).
  - 110, 111: reserved; behave as INC.
- Arithmetic:
  - All PC arithmetic is modulo 2^Psize, with silent wrap-around (max+1 -> 0; 0 + negative Offset wraps high).
  - The return address pushed by CALL is also PCout+1 modulo 2^Psize.
- Stack:
  - LIFO, register-based.
  - Top entry = entry at index SPcount-1.
  - Push and pop never occur in the same cycle.
- Fault:
  - Set on either illegal op; stays set until FaultClr=1 or reset.
  - If a fault event and FaultClr=1 occur in the same cycle, set wins.
- Full/Empty track SPcount with no extra latency.

Test Plan (Psize=5, Sdepth=4):
1. Reset/INC/wrap:
   - Assert reset with clk running -> PCout=0, SPcount=0, Fault=0 immediately.
   - Release, then 31 INC edges -> PCout=31; 1 more INC -> PCout=0.
2. Stall/JMP/BRC:
   - JMP Branchaddr=12 -> PCout=12.
   - PCen=0 for 3 cycles -> PCout stays 12.
   - BRC Offset=5'b11101 (-3), Cond=1 -> PCout=9.
   - BRC Offset=7, Cond=0 -> PCout=10.
   - From PCout=2, BRC Offset=-4, Cond=1 -> PCout=30.
3. Nested CALL/RET:
   - From PCout=3: CALL 20 -> PCout=20, SPcount=1.
   - INC -> PCout=21.
   - CALL 8 -> PCout=8, SPcount=2.
   - RET -> PCout=22; RET -> PCout=4, SPcount=0, Empty=1.
4. Overflow:
   - Four CALLs -> SPcount=4, Full=1.
   - Fifth CALL 17 -> PCout unchanged, SPcount=4, Fault=1.
   - Four RETs then return the stacked addresses in reverse order.
5. Underflow/fault clear:
   - RET with Empty=1 -> PCout held, Fault=1.
   - FaultClr=1 for one cycle -> Fault=0.
   - RET on empty with FaultClr=1 in the same cycle -> Fault=1.
6. Reset mid-sequence:
   - After two CALLs (SPcount=2), assert reset between edges -> PCout=0, SPcount=0, Empty=1 at once.
   - After release, RET -> Fault=1.
